pc_stack: RTL and testbench

- 16-bit program counter with a hardware call/return stack.
- Sits directly downstream of the 16-bit jump-target multiplexer: it consumes that mux output as its load/call target and drives the instruction-memory address.
- Extends the classic reset > load > inc > hold counter with call (push return address, jump) and ret (pop into counter).

---
 rtl/pc_stack_pkg.sv | 27 ++
 rtl/pc_stack_mem.sv | 24 ++
 rtl/pc_stack.sv | 111 +++++++++++
 tb/tb_pc_stack.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pc_stack_pkg.sv
// Shared defaults, action encodings and the per-cycle priority decoder for pc_stack.
package pc_stack_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [2:0] {
        ACT_HOLD = 3'd0,
        ACT_CLR  = 3'd1,
        ACT_CALL = 3'd2,
        ACT_RET  = 3'd3,
        ACT_LOAD = 3'd4,
        ACT_INC  = 3'd5
    } act_t;

    // Exactly one action wins per cycle: clr > call > ret > load > inc > hold.
    function automatic act_t decode_act(input logic clr, input logic call, input logic ret,
                                        input logic load, input logic inc);
        if (clr)       return ACT_CLR;
        else if (call) return ACT_CALL;
        else if (ret)  return ACT_RET;
        else if (load) return ACT_LOAD;
        else if (inc)  return ACT_INC;
        else           return ACT_HOLD;
    endfunction

endpackage

// File: rtl/pc_stack_mem.sv
// DEPTH x WIDTH return-address storage: one synchronous write port, one asynchronous read port.
// No reset; contents are only meaningful below the stack pointer.
module pc_stack_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pc_stack.sv
// Program counter with hardware call/return stack; every action visible one cycle after the edge.
// Optional PC_STACK_WRAP_EN makes the stack circular (call when full overwrites the oldest entry).
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int SPW  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] out,
    output logic [SPW-1:0]   sp,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    act_t             act;
    logic [WIDTH-1:0] out_inc;
    logic [WIDTH-1:0] rd_data;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             we;

    assign act     = decode_act(clr, call, ret, load, inc);
    assign out_inc = out + {{(WIDTH-1){1'b0}}, 1'b1};
    assign full    = (sp == SPW'(DEPTH));
    assign empty   = (sp == '0);

`ifdef PC_STACK_WRAP_EN
    // Circular index: points at the next slot to write, which is the oldest entry once full.
    logic [AW-1:0] top;
    assign wr_idx = top;
    assign rd_idx = top - AW'(1);
    assign we     = (act == ACT_CALL);
`else
    // sp == DEPTH has zero low bits, so the wrapped decrement still addresses the top entry.
    assign wr_idx = sp[AW-1:0];
    assign rd_idx = sp[AW-1:0] - AW'(1);
    assign we     = (act == ACT_CALL) && !full;
`endif

    pc_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_idx),
        .wdata (out_inc),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
`ifdef PC_STACK_WRAP_EN
            top       <= '0;
`endif
        end else begin
            case (act)
                ACT_CLR: begin
                    out       <= '0;
                    sp        <= '0;
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
`ifdef PC_STACK_WRAP_EN
                    top       <= '0;
`endif
                end
                ACT_CALL: begin
                    out <= in;
                    if (full) overflow <= 1'b1;
                    else      sp       <= sp + SPW'(1);
`ifdef PC_STACK_WRAP_EN
                    top <= top + AW'(1);
`endif
                end
                ACT_RET: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        out <= rd_data;
                        sp  <= sp - SPW'(1);
`ifdef PC_STACK_WRAP_EN
                        top <= top - AW'(1);
`endif
                    end
                end
                ACT_LOAD: out <= in;
                ACT_INC:  out <= out_inc;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
// Directed table-driven bench for pc_stack plus hand-written reset/overflow sequences.
module tb_pc_stack;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr, load, inc, call, ret;
    logic [15:0] in;
    logic [15:0] out;
    logic [3:0]  sp;
    logic        full, empty, overflow, underflow;

    int tests = 0;
    int fails = 0;

    pc_stack dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in        (in),
        .load      (load),
        .inc       (inc),
        .call      (call),
        .ret       (ret),
        .out       (out),
        .sp        (sp),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr, call, ret, load, inc;
        logic [15:0] din;
        logic [15:0] exp_out;
        logic [3:0]  exp_sp;
        logic        exp_ovf, exp_unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic ca, input logic r, input logic l,
                                input logic i, input logic [15:0] d, input logic [15:0] eo,
                                input logic [3:0] es, input logic ov, input logic un);
        vec_t v;
        v.clr = c; v.call = ca; v.ret = r; v.load = l; v.inc = i;
        v.din = d; v.exp_out = eo; v.exp_sp = es; v.exp_ovf = ov; v.exp_unf = un;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] eo, input logic [3:0] es,
                               input logic ov, input logic un);
        check({tag, ".out"}, 32'(out), 32'(eo));
        check({tag, ".sp"}, 32'(sp), 32'(es));
        check({tag, ".full"}, 32'(full), 32'(es == 4'd8));
        check({tag, ".empty"}, 32'(empty), 32'(es == 4'd0));
        check({tag, ".overflow"}, 32'(overflow), 32'(ov));
        check({tag, ".underflow"}, 32'(underflow), 32'(un));
    endtask

    task automatic step(input logic c, input logic ca, input logic r, input logic l,
                        input logic i, input logic [15:0] d);
        @(negedge clk);
        clr = c; call = ca; ret = r; load = l; inc = i; in = d;
        @(posedge clk);
        #1;
        clr = 0; call = 0; ret = 0; load = 0; inc = 0;
    endtask

    // Value pushed by call number k in the overflow sequence (first call made at out=0x0100).
    function automatic logic [15:0] pushv(input int k);
        return (k == 1) ? 16'h0101 : 16'(16'h1000 + k);
    endfunction

    initial begin
        //               clr call ret load inc  in        out       sp ovf unf
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0010, 16'h0010, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0200, 16'h0200, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0011, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0005, 16'h0005, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 16'h0300, 16'h0300, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0006, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0400, 16'h0400, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0007, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0050, 16'h0050, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0123, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0700, 16'h0700, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0020, 16'h0020, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0020, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0021, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0021, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));

        clr = 0; call = 0; ret = 0; load = 0; inc = 0; in = '0;
        reset = 1'b1;
        #12;
        check_state("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[n]) begin
            step(vecs[n].clr, vecs[n].call, vecs[n].ret, vecs[n].load, vecs[n].inc, vecs[n].din);
            check_state($sformatf("vec%0d", n), vecs[n].exp_out, vecs[n].exp_sp,
                        vecs[n].exp_ovf, vecs[n].exp_unf);
        end

        // Async reset mid-cycle with out=0x0042, sp=3.
        step(0, 1, 0, 0, 0, 16'h0010);
        step(0, 1, 0, 0, 0, 16'h0020);
        step(0, 1, 0, 0, 0, 16'h0042);
        check_state("pre_rst", 16'h0042, 4'd3, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_state("async_rst", 16'h0000, 4'd0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;

        // Overflow: 9 calls into an 8-deep stack, then drain.
        step(0, 0, 0, 1, 0, 16'h0100);
        for (int k = 1; k <= 9; k++) step(0, 1, 0, 0, 0, 16'(16'h1000 + k));
        check_state("ovf", 16'h1009, 4'd8, 1'b1, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            step(0, 0, 1, 0, 0, 16'h0000);
`ifdef PC_STACK_WRAP_EN
            check($sformatf("drain%0d.out", j), 32'(out), 32'(pushv(10 - j)));
`else
            check($sformatf("drain%0d.out", j), 32'(out), 32'(pushv(9 - j)));
`endif
            check($sformatf("drain%0d.sp", j), 32'(sp), 32'(8 - j));
        end
`ifdef PC_STACK_WRAP_EN
        step(0, 0, 1, 0, 0, 16'h0000);
        check_state("unf9", pushv(2), 4'd0, 1'b1, 1'b1);
`else
        step(0, 0, 1, 0, 0, 16'h0000);
        check_state("unf9", pushv(1), 4'd0, 1'b1, 1'b1);
`endif
        step(1, 0, 0, 0, 0, 16'h0000);
        check_state("final_clr", 16'h0000, 4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
